ext_io_target: RTL and testbench

Byte-mailbox peripheral on the SBC external I/O bus. It answers CPU cycles that the MMU decodes onto nCSEXTIO, and stretches each of those cycles by driving MRDY low for a programmable number of CLKX4 periods. It buffers bytes in two FIFOs: the CPU writes to a TX FIFO and reads from an RX FIFO. The other side of both FIFOs is a local valid/ready stream port.

---
 rtl/ext_io_target_if.sv | 12 +
 rtl/ext_io_target.sv | 139 +++++++++++++
 tb/tb_ext_io_target.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ext_io_target_if.sv
// CPU-side control signals of the SBC external I/O bus. The bidirectional DATA
// bus stays a plain module inout so its tri-state driver lives at a module boundary.
interface ext_io_target_if;
  logic       E;
  logic [7:0] ADDR;
  logic       RnW;
  logic       nCSEXTIO;
  logic       MRDY;

  modport master (output E, ADDR, RnW, nCSEXTIO, input MRDY);
  modport slave  (input E, ADDR, RnW, nCSEXTIO, output MRDY);
endinterface

// File: rtl/ext_io_target.sv
// Byte mailbox on the external I/O bus. The CPU pushes TX bytes and pops RX bytes.
// Each selected E cycle is stretched by WAIT_STATES CLKX4 periods via MRDY.
// The far side of both FIFOs is a valid/ready stream port.
module ext_io_target #(
  parameter logic [3:0]  BASE_NIBBLE = 4'h3,
  parameter int unsigned DEPTH_LOG2  = 3,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic           CLKX4,
  input  logic           nRESET,
  ext_io_target_if.slave bus,
  inout  wire [7:0]      DATA,
  output logic [7:0]     tx_data,
  output logic           tx_valid,
  input  logic           tx_ready,
  input  logic [7:0]     rx_data,
  input  logic           rx_valid,
  output logic           rx_ready
);
  localparam int unsigned Depth = 1 << DEPTH_LOG2;
  localparam int unsigned WcntW = (WAIT_STATES > 1) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [DEPTH_LOG2:0] Full = {1'b1, {DEPTH_LOG2{1'b0}}};
  // The combinational start term already covers the first low period, so the
  // counter only has to supply the remaining WAIT_STATES-1 periods.
  localparam logic [WcntW-1:0] WcntLoad = WcntW'(WAIT_STATES == 0 ? 0 : WAIT_STATES - 1);

  logic                  e_q, rnw_q, sel_q;
  logic [1:0]            reg_q;
  logic [7:0]            data_q;
  logic [WcntW-1:0]      wcnt_q;
  logic [7:0]            tx_mem [Depth];
  logic [7:0]            rx_mem [Depth];
  logic [DEPTH_LOG2-1:0] tx_wr_q, tx_rd_q, rx_wr_q, rx_rd_q;
  logic [DEPTH_LOG2:0]   tx_cnt_q, rx_cnt_q;
  logic                  tx_ovf_q, rx_ovf_q;

  logic       sel, cyc_start, commit;
  logic       wr_status, wr_data, rd_data;
  logic       cpu_push, cpu_pop, tx_pop, rx_push;
  logic [7:0] rx_head, rd_val;

  assign sel       = !bus.nCSEXTIO && (bus.ADDR[7:4] == BASE_NIBBLE) && (bus.ADDR[3:2] == 2'b00);
  assign cyc_start = bus.E && !e_q;
  // Commit uses the address/direction/data latched on the last E-high edge.
  assign commit    = !bus.E && e_q && sel_q;
  assign wr_status = commit && !rnw_q && (reg_q == 2'd0);
  assign wr_data   = commit && !rnw_q && (reg_q == 2'd1);
  assign rd_data   = commit && rnw_q && (reg_q == 2'd1);

  assign tx_valid = (tx_cnt_q != '0);
  assign rx_ready = (rx_cnt_q != Full);
  assign cpu_push = wr_data && (tx_cnt_q != Full);
  assign cpu_pop  = rd_data && (rx_cnt_q != '0);
  assign tx_pop   = tx_valid && tx_ready;
  assign rx_push  = rx_valid && rx_ready;

  assign tx_data = tx_valid ? tx_mem[tx_rd_q] : 8'h00;
  assign rx_head = (rx_cnt_q != '0) ? rx_mem[rx_rd_q] : 8'h00;

  assign bus.MRDY = !(nRESET && ((cyc_start && sel && (WAIT_STATES != 0)) || (wcnt_q != '0)));
  assign DATA     = (nRESET && bus.E && bus.RnW && sel) ? rd_val : 8'hzz;

  // Register read mux, combinational from current state.
  always_comb begin
    rd_val = 8'h00;
    unique case (bus.ADDR[1:0])
      2'd0: rd_val = {4'b0000, tx_ovf_q, rx_ovf_q, (tx_cnt_q != Full), (rx_cnt_q != '0)};
      2'd1: rd_val = rx_head;
      2'd2: rd_val = 8'(rx_cnt_q);
      2'd3: rd_val = 8'(tx_cnt_q);
      default: rd_val = 8'h00;
    endcase
  end

  // Bus cycle tracking: E edge detect, access latch and wait-state counter.
  always_ff @(posedge CLKX4) begin
    if (!nRESET) begin
      e_q    <= 1'b0;
      data_q <= 8'h00;
      rnw_q  <= 1'b0;
      sel_q  <= 1'b0;
      reg_q  <= 2'd0;
      wcnt_q <= '0;
    end else begin
      e_q <= bus.E;
      if (bus.E) begin
        data_q <= DATA;
        rnw_q  <= bus.RnW;
        sel_q  <= sel;
        reg_q  <= bus.ADDR[1:0];
      end
      if (cyc_start && sel) begin
        wcnt_q <= WcntLoad;
      end else if (wcnt_q != '0) begin
        wcnt_q <= wcnt_q - 1'b1;
      end
    end
  end

  // FIFO storage, no reset needed: occupancy is tracked by the counts.
  always_ff @(posedge CLKX4) begin
    if (cpu_push) tx_mem[tx_wr_q] <= data_q;
    if (rx_push)  rx_mem[rx_wr_q] <= rx_data;
  end

  // TX FIFO pointers, count and sticky overflow flag.
  always_ff @(posedge CLKX4) begin
    if (!nRESET) begin
      tx_wr_q  <= '0;
      tx_rd_q  <= '0;
      tx_cnt_q <= '0;
      tx_ovf_q <= 1'b0;
    end else begin
      if (cpu_push) tx_wr_q <= tx_wr_q + 1'b1;
      if (tx_pop)   tx_rd_q <= tx_rd_q + 1'b1;
      if (cpu_push && !tx_pop)      tx_cnt_q <= tx_cnt_q + 1'b1;
      else if (!cpu_push && tx_pop) tx_cnt_q <= tx_cnt_q - 1'b1;
      if (wr_data && (tx_cnt_q == Full))  tx_ovf_q <= 1'b1;
      else if (wr_status && data_q[3])    tx_ovf_q <= 1'b0;
    end
  end

  // RX FIFO pointers, count and sticky overflow flag.
  always_ff @(posedge CLKX4) begin
    if (!nRESET) begin
      rx_wr_q  <= '0;
      rx_rd_q  <= '0;
      rx_cnt_q <= '0;
      rx_ovf_q <= 1'b0;
    end else begin
      if (rx_push) rx_wr_q <= rx_wr_q + 1'b1;
      if (cpu_pop) rx_rd_q <= rx_rd_q + 1'b1;
      if (rx_push && !cpu_pop)      rx_cnt_q <= rx_cnt_q + 1'b1;
      else if (!rx_push && cpu_pop) rx_cnt_q <= rx_cnt_q - 1'b1;
      if (rx_valid && (rx_cnt_q == Full)) rx_ovf_q <= 1'b1;
      else if (wr_status && data_q[2])    rx_ovf_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ext_io_target.sv
// Directed plus random bench for ext_io_target. A queue-based mailbox model
// predicts register reads and stream outputs; a small E generator stretches the
// high phase while MRDY is low.
module tb_ext_io_target;
  localparam int unsigned Depth = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       n_reset, e, rnw, ncs, ncs0, which0;
  logic [7:0] addr;
  logic       drv;
  logic [7:0] drv_val;
  wire  [7:0] data_bus, data_bus0;
  assign data_bus  = drv ? drv_val : 8'hzz;
  assign data_bus0 = drv ? drv_val : 8'hzz;

  ext_io_target_if bus ();
  ext_io_target_if bus0 ();
  assign bus.E         = e;
  assign bus.ADDR      = addr;
  assign bus.RnW       = rnw;
  assign bus.nCSEXTIO  = ncs;
  assign bus0.E        = e;
  assign bus0.ADDR     = addr;
  assign bus0.RnW      = rnw;
  assign bus0.nCSEXTIO = ncs0;

  logic [7:0] tx_data, rx_data, tx_data0;
  logic       tx_valid, tx_ready, rx_valid, rx_ready, tx_valid0, rx_ready0;
  logic       tx_ready0 = 1'b0;
  logic       rx_valid0 = 1'b0;
  logic [7:0] rx_data0  = 8'h00;

  ext_io_target u_dut (
    .CLKX4(clk), .nRESET(n_reset), .bus(bus.slave), .DATA(data_bus),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
  );

  ext_io_target #(.WAIT_STATES(0)) u_dut0 (
    .CLKX4(clk), .nRESET(n_reset), .bus(bus0.slave), .DATA(data_bus0),
    .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready0),
    .rx_data(rx_data0), .rx_valid(rx_valid0), .rx_ready(rx_ready0)
  );

  wire       mrdy_mux = which0 ? bus0.MRDY : bus.MRDY;
  wire [7:0] data_mux = which0 ? data_bus0 : data_bus;

  int checks = 0;
  int errors = 0;

  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  logic       tx_ovf_m, rx_ovf_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    tx_q.delete();
    rx_q.delete();
    tx_ovf_m = 1'b0;
    rx_ovf_m = 1'b0;
  endtask

  // Mailbox rules applied to one CPU access; returns the expected read value.
  task automatic model_access(input logic r, input logic [1:0] rg, input logic [7:0] wd,
                              output logic [7:0] exp_rd);
    exp_rd = 8'h00;
    case (rg)
      2'd0: begin
        if (r) exp_rd = {4'b0000, tx_ovf_m, rx_ovf_m, 1'(tx_q.size() < Depth), 1'(rx_q.size() > 0)};
        else begin
          if (wd[2]) rx_ovf_m = 1'b0;
          if (wd[3]) tx_ovf_m = 1'b0;
        end
      end
      2'd1: begin
        if (r) begin
          if (rx_q.size() > 0) exp_rd = rx_q.pop_front();
        end else if (tx_q.size() < Depth) tx_q.push_back(wd);
        else tx_ovf_m = 1'b1;
      end
      2'd2: if (r) exp_rd = 8'(rx_q.size());
      default: if (r) exp_rd = 8'(tx_q.size());
    endcase
  endtask

  // One CPU bus cycle; entered and left just after a rising edge.
  task automatic cpu_cycle(input logic r, input logic [1:0] rg, input logic [7:0] wd,
                           input logic sim_push, input logic [7:0] sim_byte,
                           output logic [7:0] rd);
    int lo, hi, periods, ws;
    lo = 0; hi = 0; periods = 0; rd = 8'h00;
    ws = which0 ? 0 : 2;
    addr = {4'h3, 2'b00, rg};
    rnw  = r;
    if (which0) ncs0 = 1'b0; else ncs = 1'b0;
    drv = !r; drv_val = wd;
    @(posedge clk); #1 e = 1'b1;
    while (hi < 2 && periods < 40) begin
      @(negedge clk);
      periods++;
      if (mrdy_mux === 1'b0) lo++; else hi++;
      rd = data_mux;
      @(posedge clk);
    end
    #1 e = 1'b0;
    if (sim_push) begin
      rx_valid = 1'b1;
      rx_data  = sim_byte;
    end
    @(posedge clk); #1;
    rx_valid = 1'b0;
    ncs = 1'b1; ncs0 = 1'b1; drv = 1'b0;
    check("mrdy_low_periods", lo, ws);
    check("e_high_periods", periods, 2 + ws);
  endtask

  task automatic check_stream();
    check("tx_valid", tx_valid, 1'(tx_q.size() > 0));
    check("rx_ready", rx_ready, 1'(rx_q.size() < Depth));
    if (tx_q.size() > 0) check("tx_data", tx_data, tx_q[0]);
  endtask

  task automatic access(input logic r, input logic [1:0] rg, input logic [7:0] wd,
                        input string tag);
    logic [7:0] exp_rd, got;
    model_access(r, rg, wd, exp_rd);
    cpu_cycle(r, rg, wd, 1'b0, 8'h00, got);
    if (r) check(tag, got, exp_rd);
    check_stream();
  endtask

  task automatic stream_push(input logic [7:0] d);
    check("rx_ready_pre_push", rx_ready, 1'(rx_q.size() < Depth));
    rx_valid = 1'b1; rx_data = d;
    @(posedge clk); #1 rx_valid = 1'b0;
    if (rx_q.size() < Depth) rx_q.push_back(d); else rx_ovf_m = 1'b1;
  endtask

  task automatic stream_pop();
    check("tx_valid_pre_pop", tx_valid, 1'(tx_q.size() > 0));
    if (tx_q.size() > 0) check("tx_head", tx_data, tx_q[0]);
    tx_ready = 1'b1;
    @(posedge clk); #1 tx_ready = 1'b0;
    if (tx_q.size() > 0) tx_q.delete(0);
  endtask

  initial begin
    logic [7:0] exp_rd, got;
    int unsigned op;
    n_reset = 1'b0; e = 1'b0; rnw = 1'b1; ncs = 1'b1; ncs0 = 1'b1; which0 = 1'b0;
    addr = 8'h00; drv = 1'b0; drv_val = 8'h00;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_mrdy", bus.MRDY, 1'b1);
    check("reset_tx_valid", tx_valid, 1'b0);
    check("reset_rx_ready", rx_ready, 1'b1);
    check("reset_tx_data", tx_data, 8'h00);
    n_reset = 1'b1;
    @(posedge clk); #1;

    access(1'b1, 2'd0, 8'h00, "status_after_reset");

    // CPU sends two bytes, consumer drains them on successive edges.
    access(1'b0, 2'd1, 8'hA5, "wr_a5");
    access(1'b0, 2'd1, 8'h5A, "wr_5a");
    stream_pop();
    stream_pop();
    access(1'b1, 2'd3, 8'h00, "txcount_empty");

    // Producer overfills the RX FIFO by one.
    for (int i = 0; i < 9; i++) stream_push(8'h10 + 8'(i));
    access(1'b1, 2'd0, 8'h00, "status_rx_ovf");
    access(1'b1, 2'd2, 8'h00, "rxcount_full");
    for (int i = 0; i < 9; i++) access(1'b1, 2'd1, 8'h00, "rx_pop");
    access(1'b1, 2'd2, 8'h00, "rxcount_drained");
    access(1'b0, 2'd0, 8'h04, "clr_rx_ovf");
    access(1'b1, 2'd0, 8'h00, "status_cleared");

    // CPU overfills the TX FIFO, then clears tx_ovf and drains.
    for (int i = 0; i < 9; i++) access(1'b0, 2'd1, 8'h80 + 8'(i), "tx_fill");
    access(1'b1, 2'd0, 8'h00, "status_tx_ovf");
    access(1'b0, 2'd2, 8'hFF, "wr_rxcount_ignored");
    access(1'b0, 2'd0, 8'h08, "clr_tx_ovf");
    access(1'b1, 2'd0, 8'h00, "status_tx_clr");
    for (int i = 0; i < 8; i++) stream_pop();

    // CPU pop and stream push land on the same edge.
    stream_push(8'h21);
    model_access(1'b1, 2'd1, 8'h00, exp_rd);
    rx_q.push_back(8'h22);
    cpu_cycle(1'b1, 2'd1, 8'h00, 1'b1, 8'h22, got);
    check("sim_pop_data", got, exp_rd);
    access(1'b1, 2'd2, 8'h00, "sim_rxcount");
    access(1'b1, 2'd1, 8'h00, "sim_next_read");

    // Reset dropped while MRDY is low during a TX write.
    addr = 8'h31; rnw = 1'b0; ncs = 1'b0; drv = 1'b1; drv_val = 8'h77;
    @(posedge clk); #1 e = 1'b1;
    @(negedge clk);
    check("abort_mrdy_low", bus.MRDY, 1'b0);
    #1 n_reset = 1'b0;
    #1 check("abort_mrdy_release", bus.MRDY, 1'b1);
    @(posedge clk); #1 e = 1'b0;
    @(posedge clk); #1;
    ncs = 1'b1; drv = 1'b0; n_reset = 1'b1;
    model_reset();
    check("abort_tx_valid", tx_valid, 1'b0);
    access(1'b1, 2'd3, 8'h00, "abort_txcount");

    // Random mix of stream and CPU traffic.
    for (int i = 0; i < 80; i++) begin
      op = $urandom_range(0, 5);
      case (op)
        0: stream_push(8'($urandom));
        1: stream_pop();
        2, 3: access(1'b0, 2'($urandom_range(0, 3)), 8'($urandom), "rand_wr");
        default: access(1'b1, 2'($urandom_range(0, 3)), 8'h00, "rand_rd");
      endcase
    end

    // Instance without wait states.
    which0 = 1'b1;
    cpu_cycle(1'b0, 2'd1, 8'h3C, 1'b0, 8'h00, got);
    check("ws0_tx_valid", tx_valid0, 1'b1);
    check("ws0_tx_data", tx_data0, 8'h3C);
    cpu_cycle(1'b1, 2'd3, 8'h00, 1'b0, 8'h00, got);
    check("ws0_txcount", got, 8'h01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
